// File: rtl/round_controller.sv
// Round controller for the lander game: tracks lives, per-attempt time budget and the
// land/crash hold sequences, and requests respawns and level clears.
module round_controller #(
  parameter int unsigned LIVES      = 3,
  parameter int unsigned TIME_LIMIT = 99,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [2:0] level,
  input  logic       landed,
  input  logic       crashed,
  input  logic       restart,
  output logic       clear,
  output logic       respawn,
  output logic [1:0] lives,
  output logic [6:0] time_left,
  output logic       game_over
);

  typedef enum logic [2:0] {
    StIdle,
    StPlay,
    StLandHold,
    StLevelWait,
    StCrashHold,
    StGameOver
  } state_e;

  localparam logic [1:0] LivesInit = 2'(LIVES);
  localparam logic [6:0] TimeInit  = 7'(TIME_LIMIT);
  localparam logic [3:0] HoldLast  = 4'(HOLD_TICKS - 1);

  state_e     state_q;
  logic [1:0] lives_q;
  logic [6:0] time_q;
  logic [3:0] hold_q;
  logic [2:0] cap_q;
  logic       clear_q, respawn_q, game_over_q;

  logic level_zero, level_play, in_round;

  assign level_zero = (level == 3'd0);
  assign level_play = !level_zero && (level <= 3'd3);
  assign in_round   = (state_q == StPlay) || (state_q == StLandHold) ||
                      (state_q == StLevelWait) || (state_q == StCrashHold);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      lives_q     <= LivesInit;
      time_q      <= TimeInit;
      hold_q      <= 4'd0;
      cap_q       <= 3'd0;
      clear_q     <= 1'b0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      respawn_q <= 1'b0;
      // Dropping back to the start screen overrides anything else happening in a round.
      if (in_round && level_zero) begin
        state_q <= StIdle;
        lives_q <= LivesInit;
        time_q  <= TimeInit;
        clear_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            lives_q     <= LivesInit;
            time_q      <= TimeInit;
            clear_q     <= 1'b0;
            game_over_q <= 1'b0;
            if (level_play) begin
              state_q   <= StPlay;
              respawn_q <= 1'b1;
            end
          end
          StPlay: begin
            if (crashed || (frame_tick && time_q == 7'd1)) begin
              state_q <= StCrashHold;
              lives_q <= (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
              hold_q  <= 4'd0;
            end else if (landed) begin
              state_q <= StLandHold;
              cap_q   <= level;
              hold_q  <= 4'd0;
              clear_q <= 1'b1;
            end else if (frame_tick && time_q != 7'd0) begin
              time_q <= time_q - 7'd1;
            end
          end
          StLandHold: begin
            if (frame_tick) begin
              if (hold_q == HoldLast) begin
                state_q <= StLevelWait;
                clear_q <= 1'b0;
              end else begin
                hold_q <= hold_q + 4'd1;
              end
            end
          end
          StLevelWait: begin
            if (level != cap_q) begin
              if (level_play) begin
                state_q   <= StPlay;
                time_q    <= TimeInit;
                respawn_q <= 1'b1;
              end else if (level == 3'd4) begin
                state_q <= StIdle;
                lives_q <= LivesInit;
                time_q  <= TimeInit;
              end
            end
          end
          StCrashHold: begin
            if (frame_tick) begin
              if (hold_q != HoldLast) begin
                hold_q <= hold_q + 4'd1;
              end else if (lives_q == 2'd0) begin
                state_q     <= StGameOver;
                game_over_q <= 1'b1;
              end else begin
                state_q   <= StPlay;
                time_q    <= TimeInit;
                respawn_q <= 1'b1;
              end
            end
          end
          StGameOver: begin
            if (restart) begin
              state_q     <= StIdle;
              lives_q     <= LivesInit;
              time_q      <= TimeInit;
              game_over_q <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign clear     = clear_q;
  assign respawn   = respawn_q;
  assign lives     = lives_q;
  assign time_left = time_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural model of the round rules.
module tb_round_controller;

  localparam int L = 3;
  localparam int T = 99;
  localparam int H = 8;

  logic       Clock      = 1'b0;
  logic       Reset      = 1'b0;
  logic       frame_tick = 1'b0;
  logic [2:0] level      = 3'd0;
  logic       landed     = 1'b0;
  logic       crashed    = 1'b0;
  logic       restart    = 1'b0;
  logic       clear, respawn, game_over;
  logic [1:0] lives;
  logic [6:0] time_left;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  round_controller #(
    .LIVES      (L),
    .TIME_LIMIT (T),
    .HOLD_TICKS (H)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .level      (level),
    .landed     (landed),
    .crashed    (crashed),
    .restart    (restart),
    .clear      (clear),
    .respawn    (respawn),
    .lives      (lives),
    .time_left  (time_left),
    .game_over  (game_over)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase number, lives, ticks left, hold ticks remaining.
  localparam int MIdle = 0, MPlay = 1, MLand = 2, MWait = 3, MCrash = 4, MOver = 5;
  int m_ph, m_lives, m_time, m_hold_left, m_cap;
  bit m_clear, m_resp, m_go;

  function automatic void m_idle();
    m_ph = MIdle; m_lives = L; m_time = T; m_clear = 0; m_go = 0;
  endfunction

  function automatic void m_enter_play();
    m_ph = MPlay; m_time = T; m_resp = 1;
  endfunction

  function automatic void m_lose_life();
    if (m_lives > 0) m_lives--;
    m_ph = MCrash; m_hold_left = H;
  endfunction

  function automatic void m_step();
    int lv;
    lv = int'(level);
    m_resp = 0;
    if (lv == 0 && m_ph inside {MPlay, MLand, MWait, MCrash}) m_idle();
    else case (m_ph)
      MIdle: begin
        m_idle();
        if (lv >= 1 && lv <= 3) m_enter_play();
      end
      MPlay: begin
        if (crashed) m_lose_life();
        else if (landed) begin
          m_ph = MLand; m_cap = lv; m_hold_left = H; m_clear = 1;
        end else if (frame_tick) begin
          if (m_time == 1) m_lose_life();
          else if (m_time > 0) m_time--;
        end
      end
      MLand: if (frame_tick) begin
        m_hold_left--;
        if (m_hold_left == 0) begin m_ph = MWait; m_clear = 0; end
      end
      MWait: if (lv != m_cap) begin
        if (lv >= 1 && lv <= 3) m_enter_play();
        else if (lv == 4) m_idle();
      end
      MCrash: if (frame_tick) begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          if (m_lives == 0) begin m_ph = MOver; m_go = 1; end
          else m_enter_play();
        end
      end
      MOver: if (restart) m_idle();
      default: m_idle();
    endcase
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_idle(); m_hold_left = 0; m_cap = 0; m_resp = 0;
    end else begin
      m_step();
    end
  end

  always @(negedge Clock) begin
    if (cmp_en) begin
      chk("model_clear", clear, m_clear);
      chk("model_respawn", respawn, m_resp);
      chk("model_lives", lives, m_lives);
      chk("model_time_left", time_left, m_time);
      chk("model_game_over", game_over, m_go);
    end
  end

  task automatic step(input logic tick);
    frame_tick = tick;
    @(posedge Clock);
    #1;
    frame_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #2;
    chk("rst_lives", lives, 3);
    chk("rst_time", time_left, 99);
    chk("rst_clear", clear, 0);
    chk("rst_respawn", respawn, 0);
    chk("rst_game_over", game_over, 0);
    Reset  = 1'b1;
    cmp_en = 1'b1;

    // Start of level 1, then a few frames.
    level = 3'd1; step(0);
    chk("start_respawn", respawn, 1);
    chk("start_time", time_left, 99);
    chk("start_lives", lives, 3);
    step(0);
    chk("respawn_one_cycle", respawn, 0);
    repeat (5) step(1);
    chk("five_ticks_time", time_left, 94);

    // Landing: clear for exactly the hold, then next level respawns.
    landed = 1'b1; step(0); landed = 1'b0;
    chk("land_clear_on", clear, 1);
    chk("land_time_frozen", time_left, 94);
    repeat (7) step(1);
    chk("land_clear_tick7", clear, 1);
    step(1);
    chk("land_clear_off", clear, 0);
    level = 3'd2; step(0);
    chk("next_level_respawn", respawn, 1);
    chk("next_level_time", time_left, 99);
    chk("next_level_lives", lives, 3);

    // Crash beats landing in the same cycle.
    crashed = 1'b1; landed = 1'b1; step(0); crashed = 1'b0; landed = 1'b0;
    chk("crash_lives", lives, 2);
    chk("crash_no_clear", clear, 0);
    repeat (7) step(1);
    chk("crash_hold_no_respawn", respawn, 0);
    step(1);
    chk("crash_respawn", respawn, 1);
    chk("crash_time_reload", time_left, 99);

    // Two timeouts drain the remaining lives.
    repeat (98) step(1);
    chk("pre_timeout_time", time_left, 1);
    chk("pre_timeout_lives", lives, 2);
    step(1);
    chk("timeout1_lives", lives, 1);
    chk("timeout1_time", time_left, 1);
    repeat (8) step(1);
    chk("timeout1_respawn", respawn, 1);
    repeat (99) step(1);
    chk("timeout2_lives", lives, 0);
    repeat (8) step(1);
    chk("game_over_set", game_over, 1);
    chk("game_over_no_respawn", respawn, 0);
    restart = 1'b1; step(0); restart = 1'b0;
    chk("restart_game_over", game_over, 0);
    chk("restart_lives", lives, 3);

    // Final level cleared, sequencer moves to finish: back to idle without respawn.
    level = 3'd3; step(0);
    chk("lvl3_respawn", respawn, 1);
    landed = 1'b1; step(0); landed = 1'b0;
    repeat (8) step(1);
    chk("lvl3_clear_off", clear, 0);
    level = 3'd4; step(0);
    chk("finish_no_respawn", respawn, 0);
    chk("finish_lives", lives, 3);
    step(0);
    chk("finish_still_no_respawn", respawn, 0);

    // Reset in the middle of a landing hold.
    level = 3'd1; step(0);
    landed = 1'b1; step(0); landed = 1'b0;
    repeat (3) step(1);
    chk("hold_clear_before_reset", clear, 1);
    Reset = 1'b0;
    #1;
    chk("reset_clear_async", clear, 0);
    chk("reset_lives_async", lives, 3);
    chk("reset_respawn_async", respawn, 0);
    step(0);
    Reset = 1'b1;
    step(0);
    chk("post_reset_respawn", respawn, 1);

    // Random play.
    for (int c = 0; c < 6000; c++) begin
      if (!Reset) Reset = 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        r = int'($urandom_range(0, 9));
        level = (r == 0) ? 3'd0 : 3'(r % 4 + 1);
      end
      frame_tick = ($urandom_range(0, 1) == 1);
      landed     = ($urandom_range(0, 29) == 0);
      crashed    = ($urandom_range(0, 39) == 0);
      restart    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2;
        Reset = 1'b0;
      end
      @(posedge Clock);
      #1;
    end
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
